// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 burst responder backed by a 64-bit-wide internal SRAM.
// Read and write channels are independent and each accepts one outstanding
// burst. Optional build macro: AXI_SLV_ERR_EN. When it is defined, bursts
// starting outside the mapped window get DECERR, and in-range writes with a
// misplaced wlast get SLVERR.
//
// Handshake rule (all channels): a transfer happens on the rising clk edge
// where both valid and ready are high. A source that raises valid holds it,
// together with its payload, stable until that edge.
module axi_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  input  logic [1:0]  arburst,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  input  logic [1:0]  awburst,
  input  logic [7:0]  awlen,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic        wlast,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  o_dbg_rd_state,
  output logic [1:0]  o_dbg_wr_state
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Byte address -> array word; the window repeats every DEPTH_WORDS words.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 3);
  endfunction

  // FIXED bursts revisit one address; INCR and WRAP both step by a word.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd8;
  endfunction

  logic [63:0] r_mem [DEPTH_WORDS];

  // Read channel state
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  logic [31:0] r_raddr;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rcnt;
  logic [7:0]  r_lat_cnt;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rvalid;
  logic        r_rerr;
  logic        w_rd_load;
  logic        w_rd_advance;
  logic        w_rd_done;
  logic        w_rd_is_last;
  logic [31:0] w_rd_addr_nxt;
  logic [31:0] w_rd_fetch_addr;
  logic [AW-1:0] w_rd_fetch_idx;

  // Write channel state
  wr_state_t   r_wr_state;
  wr_state_t   w_wr_next;
  logic [31:0] r_waddr;
  logic [1:0]  r_wburst;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wcnt;
  logic        r_werr;
  logic [1:0]  r_bresp;
  logic        w_wr_beat;
  logic        w_wlast_exp;
  logic [AW-1:0] w_wr_idx;

  // Error-detection hooks
  logic w_ar_err;
  logic w_aw_err;
  logic w_wlast_bad;
  logic w_unused_ok;

`ifdef AXI_SLV_ERR_EN
  localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd8;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  assign w_ar_err    = !in_range(araddr);
  assign w_aw_err    = !in_range(awaddr);
  assign w_wlast_bad = (wlast != w_wlast_exp);
  assign w_unused_ok = ^{arsize};
`else
  assign w_ar_err    = 1'b0;
  assign w_aw_err    = 1'b0;
  assign w_wlast_bad = 1'b0;
  assign w_unused_ok = ^{arsize, wlast};
`endif

  assign w_rd_is_last    = (r_rcnt == r_rlen);
  assign w_rd_addr_nxt   = next_addr(r_raddr, r_rburst);
  assign w_rd_fetch_addr = w_rd_advance ? w_rd_addr_nxt : r_raddr;
  assign w_rd_fetch_idx  = word_idx(w_rd_fetch_addr);

  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rvalid = r_rvalid;
  assign rlast  = r_rvalid && w_rd_is_last;

  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_wr_idx    = word_idx(r_waddr);
  assign bresp       = r_bresp;

  assign o_dbg_rd_state = r_rd_state;
  assign o_dbg_wr_state = r_wr_state;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_rd_state <= R_IDLE;
    else     r_rd_state <= w_rd_next;
  end

  // Read FSM next state plus the load/advance/done strobes for the datapath.
  always_comb begin
    w_rd_next    = r_rd_state;
    arready      = 1'b0;
    w_rd_load    = 1'b0;
    w_rd_advance = 1'b0;
    w_rd_done    = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) w_rd_next = R_LAT;
      end
      R_LAT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_rd_load = 1'b1;
          w_rd_next = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (w_rd_is_last) begin
            w_rd_done = 1'b1;
            w_rd_next = R_IDLE;
          end else begin
            w_rd_advance = 1'b1;
          end
        end
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read datapath: burst bookkeeping and the registered beat (data/resp/valid).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr   <= '0;
      r_rburst  <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rvalid  <= 1'b0;
      r_rerr    <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        r_raddr   <= araddr;
        r_rburst  <= arburst;
        r_rlen    <= arlen;
        r_rcnt    <= '0;
        r_lat_cnt <= '0;
        r_rerr    <= w_ar_err;
      end
      if (r_rd_state == R_LAT && !w_rd_load) r_lat_cnt <= r_lat_cnt + 8'd1;
      // The array is read here with a non-blocking update, so a write landing
      // on the same edge is not visible to this beat.
      if (w_rd_load || w_rd_advance) begin
        r_rdata  <= r_rerr ? 64'd0 : r_mem[w_rd_fetch_idx];
        r_rresp  <= r_rerr ? 2'b11 : 2'b00;
        r_rvalid <= 1'b1;
      end
      if (w_rd_advance) begin
        r_raddr <= w_rd_addr_nxt;
        r_rcnt  <= r_rcnt + 8'd1;
      end
      if (w_rd_done) r_rvalid <= 1'b0;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wr_state <= W_IDLE;
    else     r_wr_state <= w_wr_next;
  end

  // Write FSM next state and channel ready/valid outputs.
  always_comb begin
    w_wr_next = r_wr_state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    w_wr_beat = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wr_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          w_wr_beat = 1'b1;
          // The beat count alone ends the burst; wlast only feeds the error check.
          if (w_wlast_exp) w_wr_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Write bookkeeping: address/counter per beat and the accumulated response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr  <= '0;
      r_wburst <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= '0;
    end else begin
      if (awvalid && awready) begin
        r_waddr  <= awaddr;
        r_wburst <= awburst;
        r_wlen   <= awlen;
        r_wcnt   <= '0;
        r_werr   <= w_aw_err;
        r_bresp  <= w_aw_err ? 2'b11 : 2'b00;
      end
      if (w_wr_beat) begin
        r_waddr <= next_addr(r_waddr, r_wburst);
        r_wcnt  <= r_wcnt + 8'd1;
        if (!r_werr && w_wlast_bad) r_bresp <= 2'b10;
      end
    end
  end

  // Byte-lane array writes. No reset here, so contents survive rst; a beat
  // presented during reset is abandoned rather than written.
  always_ff @(posedge clk) begin
    if (w_wr_beat && !r_werr && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed bench for axi_mem_slave. A table of single-beat
// write/read records is applied in a loop. Hand-written sequences then cover
// bursts, backpressure, same-cycle read/write, early wvalid, FIXED bursts,
// 256-beat bursts and reset.
// Inputs are driven and outputs sampled on the falling clk edge.
module tb_axi_mem_slave;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic        awready;
  logic [63:0] wdata;
  logic        wlast;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  dbg_rd_state;
  logic [1:0]  dbg_wr_state;

  int n_vec;
  int n_mis;

  logic [63:0] rd_q[$];
  logic        rl_q[$];
  logic [1:0]  rs_q[$];
  int          rd_lat;
  logic        ar_after;
  logic        rv_after;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen),
    .arsize(arsize), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen),
    .awready(awready),
    .wdata(wdata), .wlast(wlast), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .o_dbg_rd_state(dbg_rd_state), .o_dbg_wr_state(dbg_wr_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Write burst driver: beat b carries d0+b; wlast is set on the final beat.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [63:0] d0,
                          input logic [7:0] strb, output logic [1:0] resp);
    int t;
    resp    = 2'bxx;
    awaddr  = addr;
    awlen   = len;
    awburst = burst;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    if (!awready) begin timeout_fail("aw_handshake"); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1;
      wdata  = d0 + 64'(b);
      wstrb  = strb;
      wlast  = (b == int'(len));
      t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      if (!wready) begin timeout_fail("w_beat"); wvalid = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    if (!bvalid) begin timeout_fail("b_resp"); bready = 1'b0; return; end
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Read burst driver. mode 0: rready always 1; mode 1: rready follows
  // 1,0,0,1,0,0... over cycles where rvalid is high. Collects beats into
  // rd_q/rl_q/rs_q and checks stability of stalled beats.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode);
    int t;
    int cyc;
    logic done;
    logic rr;
    logic held_v;
    logic [63:0] held_d;
    logic held_l;
    rd_q.delete();
    rl_q.delete();
    rs_q.delete();
    rd_lat  = -1;
    araddr  = addr;
    arlen   = len;
    arburst = burst;
    arsize  = 3'd3;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    if (!arready) begin timeout_fail("ar_handshake"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 0; t = 0; done = 1'b0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
    while (!done && t < 2000) begin
      rr = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (rvalid && rd_lat < 0) rd_lat = t;
      if (held_v) begin
        check("r_stall_data", rdata, held_d);
        check("r_stall_last", 64'(rlast), 64'(held_l));
        held_v = 1'b0;
      end
      rready = rr;
      if (rvalid) begin
        cyc++;
        if (rr) begin
          rd_q.push_back(rdata);
          rl_q.push_back(rlast);
          rs_q.push_back(rresp);
          if (rlast) done = 1'b1;
        end else begin
          held_v = 1'b1;
          held_d = rdata;
          held_l = rlast;
        end
      end
      @(negedge clk);
      t++;
    end
    if (!done) timeout_fail("r_burst");
    ar_after = arready;
    rv_after = rvalid;
    rready   = 1'b0;
  endtask

  initial begin
    logic [1:0] resp;
    int t;
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; arburst = 2'b01; arlen = '0; arsize = 3'd3; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; awburst = 2'b01; awlen = '0;
    wdata = '0; wlast = 1'b0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // Single-beat vector table
    vecs.push_back('{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0018, 64'h0, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0018, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0018, 64'hAABB_CCDD_1122_3344, 8'hF0, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0018, 64'h0, 8'h00, 64'hAABB_CCDD_FFFF_FFFF, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0020, 64'h0, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0020, 64'h1234_5678_9ABC_DEF0, 8'h81, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0020, 64'h0, 8'h00, 64'h1200_0000_0000_00F0, 2'b00});
`ifndef AXI_SLV_ERR_EN
    vecs.push_back('{1'b1, 32'h8000_8000, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h0102_0304_0506_0708, 2'b00});
    vecs.push_back('{1'b1, 32'h7FFF_FFF8, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_7FF8, 64'h0, 8'h00, 64'hCAFE_F00D_DEAD_BEEF, 2'b00});
`else
    vecs.push_back('{1'b1, 32'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 2'b11});
    vecs.push_back('{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h0102_0304_0506_0708, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_8000, 64'h0, 8'h00, 64'h0, 2'b11});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rdata",   rdata,        64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-beat transactions
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, 8'd0, 2'b01, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 8'd0, 2'b01, 0);
        check($sformatf("vec%0d_beats", i), 64'(rd_q.size()), 64'd1);
        if (rd_q.size() == 1) begin
          check($sformatf("vec%0d_rdata", i), rd_q[0], vecs[i].exp_data);
          check($sformatf("vec%0d_rresp", i), 64'(rs_q[0]), 64'(vecs[i].exp_resp));
          check($sformatf("vec%0d_rlast", i), 64'(rl_q[0]), 64'd1);
        end
      end
    end

    // Two-beat INCR read: latency, order, rlast placement, arready afterwards
    do_write(32'h8000_0008, 8'd0, 2'b01, 64'hA1A1_A1A1_0000_0001, 8'hFF, resp);
    do_write(32'h8000_0010, 8'd0, 2'b01, 64'hB2B2_B2B2_0000_0002, 8'hFF, resp);
    do_read(32'h8000_0008, 8'd1, 2'b01, 0);
    check("rd2_latency", 64'(rd_lat), 64'd1);
    check("rd2_beats", 64'(rd_q.size()), 64'd2);
    if (rd_q.size() == 2) begin
      check("rd2_beat0", rd_q[0], 64'hA1A1_A1A1_0000_0001);
      check("rd2_beat1", rd_q[1], 64'hB2B2_B2B2_0000_0002);
      check("rd2_rlast0", 64'(rl_q[0]), 64'd0);
      check("rd2_rlast1", 64'(rl_q[1]), 64'd1);
    end
    check("rd2_arready_after", 64'(ar_after), 64'd1);
    check("rd2_rvalid_after", 64'(rv_after), 64'd0);

    // Four-beat write burst, then read it back under rready backpressure
    do_write(32'h8000_0040, 8'd3, 2'b01, 64'h4000_0000_0000_0000, 8'hFF, resp);
    check("wr4_bresp", 64'(resp), 64'd0);
    do_read(32'h8000_0040, 8'd3, 2'b01, 1);
    check("bp_beats", 64'(rd_q.size()), 64'd4);
    if (rd_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("bp_beat%0d", i), rd_q[i], 64'h4000_0000_0000_0000 + 64'(i));
        check($sformatf("bp_rlast%0d", i), 64'(rl_q[i]), (i == 3) ? 64'd1 : 64'd0);
      end
    end

    // FIXED bursts stay on one word
    do_write(32'h8000_0108, 8'd0, 2'b01, 64'h0, 8'hFF, resp);
    do_write(32'h8000_0100, 8'd2, 2'b00, 64'h5500, 8'hFF, resp);
    do_read(32'h8000_0100, 8'd2, 2'b00, 0);
    check("fixed_beats", 64'(rd_q.size()), 64'd3);
    if (rd_q.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("fixed_beat%0d", i), rd_q[i], 64'h5502);
    end
    do_read(32'h8000_0108, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("fixed_neighbour", rd_q[0], 64'h0);
    else timeout_fail("fixed_neighbour");

    // 256-beat bursts
    do_write(32'h8000_1000, 8'd255, 2'b01, 64'h7700_0000_0000_0000, 8'hFF, resp);
    check("wr256_bresp", 64'(resp), 64'd0);
    do_read(32'h8000_1000, 8'd255, 2'b01, 0);
    check("rd256_beats", 64'(rd_q.size()), 64'd256);
    if (rd_q.size() == 256) begin
      for (int i = 0; i < 256; i++)
        check($sformatf("rd256_beat%0d", i), rd_q[i], 64'h7700_0000_0000_0000 + 64'(i));
      check("rd256_rlast_mid", 64'(rl_q[254]), 64'd0);
      check("rd256_rlast_end", 64'(rl_q[255]), 64'd1);
    end

    // wvalid before the AW handshake is stalled, not dropped
    wvalid = 1'b1; wdata = 64'h9999; wstrb = 8'hFF; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early_w_wready", 64'(wready), 64'd0);
    end
    awaddr = 32'h8000_0030; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("early_w_wready_after_aw", 64'(wready), 64'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    if (!bvalid) timeout_fail("early_w_bvalid");
    else check("early_w_bresp", 64'(bresp), 64'd0);
    @(negedge clk);
    bready = 1'b0;
    do_read(32'h8000_0030, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("early_w_data", rd_q[0], 64'h9999);
    else timeout_fail("early_w_data");

    // Same-cycle read and write of word 5
    do_write(32'h8000_0028, 8'd0, 2'b01, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, resp);
    araddr = 32'h8000_0028; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    awaddr = 32'h8000_0028; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    check("conc_arready", 64'(arready), 64'd1);
    check("conc_awready", 64'(awready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'h600D_600D_600D_600D; wstrb = 8'hFF; wlast = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    check("conc_rvalid", 64'(rvalid), 64'd1);
    check("conc_old_data", rdata, 64'h0BAD_0BAD_0BAD_0BAD);
    check("conc_rlast", 64'(rlast), 64'd1);
    check("conc_bvalid", 64'(bvalid), 64'd1);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    check("conc_rvalid_done", 64'(rvalid), 64'd0);
    check("conc_bvalid_done", 64'(bvalid), 64'd0);
    do_read(32'h8000_0028, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("conc_new_data", rd_q[0], 64'h600D_600D_600D_600D);
    else timeout_fail("conc_new_data");

    // Reset in the middle of a write burst
    awaddr = 32'h8000_0200; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'h1111; wstrb = 8'hFF; wlast = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    check("midrst_awready", 64'(awready), 64'd1);
    check("midrst_arready", 64'(arready), 64'd1);
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    do_write(32'h8000_0200, 8'd0, 2'b01, 64'h2222_3333_4444_5555, 8'hFF, resp);
    check("postrst_bresp", 64'(resp), 64'd0);
    do_read(32'h8000_0200, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("postrst_data", rd_q[0], 64'h2222_3333_4444_5555);
    else timeout_fail("postrst_data");
    do_read(32'h8000_0040, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("postrst_mem_kept", rd_q[0], 64'h4000_0000_0000_0000);
    else timeout_fail("postrst_mem_kept");

`ifdef AXI_SLV_ERR_EN
    // Out-of-window write is refused with DECERR and leaves memory alone
    do_write(32'h0000_0000, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp);
    check("decerr_bresp", 64'(resp), 64'd3);
    do_read(32'h8000_0000, 8'd0, 2'b01, 0);
    if (rd_q.size() == 1) check("decerr_mem_kept", rd_q[0], 64'h0102_0304_0506_0708);
    else timeout_fail("decerr_mem_kept");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
